fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives it to the memory's pc input.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect with flush, syscall halt and misaligned-target error.

Parameters:
PC_W, 8, program-counter width (byte address into 256-byte instruction memory)
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset (must be word-aligned)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_out  out  PC_W  current fetch address to instruction memory pc input
instr_in  in  INSTR_W  instruction from memory; combinational read of pc_out, valid in the same cycle
stall  in  1  hazard stall from decode; hold PC and IF/ID
branch_taken  in  1  branch resolved taken in EX
branch_target  in  PC_W  branch destination
jump  in  1  jump decoded in ID
jump_target  in  PC_W  jump destination
ifid_instr  out  INSTR_W  registered instruction to decode (0 = nop bubble)
ifid_pc4  out  PC_W  registered PC+4 of ifid_instr
ifid_valid  out  1  ifid_instr is a real instruction
halted  out  1  fetch halted on syscall
fetch_err  out  1  misaligned redirect target seen; sticky

Behaviour:
Reset (async, immediate on rst=1):
- pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, fetch_err=0, state=RUN.

States: RUN, HALT, ERR. halted=1 only in HALT; fetch_err=1 only in ERR (Moore outputs).

RUN, per rising edge, priority high to low:
1. branch_taken=1:
   - If branch_target[1:0]!=0: pc held, IF/ID <= bubble, state->ERR.
   - Else: pc<=branch_target, IF/ID <= bubble (instr=0, valid=0, pc4=0).
   - Applies even when stall=1.
2. jump=1: same alignment check and redirect using jump_target; IF/ID <= bubble; overrides stall.
3. stall=1: pc and all IF/ID outputs hold their values.
4. Normal:
   - ifid_instr<=instr_in, ifid_pc4<=pc+4, ifid_valid<=1.
   - If instr_in==32'h0000000C (syscall): pc holds and state->HALT.
   - Else pc<=pc+4.

Arithmetic:
- pc+4 is modulo 2^PC_W; 252+4 wraps to 0 with no flag.
- pc[1:0] is always 00.

HALT:
- pc holds; IF/ID <= bubble every cycle unless stall=1 (stall holds).
- branch_taken=1 (older instruction redirects, so the syscall was speculative): same as RUN rule 1, state->RUN (or ERR if misaligned).
- jump is ignored in HALT.

ERR:
- pc holds; IF/ID <= bubble; all inputs ignored until rst.

Latency:
- Instruction at address A appears on ifid_instr one clock after pc_out=A, given no stall and no redirect.
- A redirect at edge N means pc_out=target after N; the target instruction reaches IF/ID after N+1.

Test Plan:
1. Reset and sequential fetch:
   - Stimulus: rst pulse; memory words 0x11,0x22,0x33 at 0,4,8; no control inputs.
   - Required: pc_out = 0,4,8,12 on successive cycles; ifid_instr = 0x11,0x22,0x33 one cycle behind; ifid_pc4 = 4,8,12; ifid_valid rises on the first edge after reset.
2. Stall and branch priority:
   - Stimulus: stall=1 for 2 cycles at pc=8, then branch_taken=1 with target 0x40 while stall=1.
   - Required: pc_out stays 8 and IF/ID frozen during the stall; on the branch edge pc_out=0x40, ifid_valid=0, ifid_instr=0.
3. Wrap-around:
   - Stimulus: jump to 0xFC.
   - Required: after the bubble, pc_out sequence is 0xFC, 0x00; ifid_pc4 for the 0xFC instruction is 0x00.
4. Syscall halt and cancel:
   - Stimulus: memory[0x10]=0x0000000C, fetch through it; hold 3 cycles; then branch_taken=1 to 0x20.
   - Required: syscall latched with valid=1; pc_out stays 0x10 and halted=1; bubbles follow; after the branch halted=0, pc_out=0x20, fetch resumes.
5. Misaligned target:
   - Stimulus: branch_taken=1 with target 0x06.
   - Required: fetch_err=1 and stays 1; pc_out unchanged; ifid_valid=0 regardless of later jump/branch until rst.
6. Async reset mid-operation:
   - Stimulus: assert rst between clock edges while stall=1 and pc=0x24.
   - Required: pc_out=0 and ifid_valid=0 immediately, without waiting for a clock edge; normal fetch from 0 after rst deasserts.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, captures the instruction
// returned combinationally by the instruction memory into the IF/ID register,
// and handles stall, branch/jump redirect with flush, syscall halt and
// misaligned-redirect error.
module fetch_stage #(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      INSTR_W  = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc4,
  output logic               ifid_valid,
  output logic               halted,
  output logic               fetch_err
);

  // Fetch control states. ERR is only left through reset.
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [INSTR_W-1:0] SYSCALL = INSTR_W'(32'h0000_000C);
  localparam logic [PC_W-1:0]    PC_STEP = PC_W'(4);

  // Architectural state and its next-state values.
  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic               valid_q, valid_d;

  // Redirect helpers. A branch resolved in EX is older than a jump decoded in
  // ID, so its target wins when both arrive in the same cycle.
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_tgt;
  logic            tgt_misaligned;

  // Sequential PC increment wraps modulo 2^PC_W with no carry-out.
  assign pc_plus4       = pc_q + PC_STEP;
  assign redirect_tgt   = branch_taken ? branch_target : jump_target;
  assign tgt_misaligned = (redirect_tgt[1:0] != 2'b00);

  // Next-state and IF/ID update selection, priority ordered per state.
  always_comb begin
    // NOTE: every signal assigned here gets a hold default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    case (state_q)
      ST_RUN: begin
        if (branch_taken || jump) begin
          // Redirect flushes the wrong-path instruction, even under stall.
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (tgt_misaligned) begin
            state_d = ST_ERR;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (!stall) begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (instr_in == SYSCALL) begin
            // Pass the syscall to decode but stop fetching past it.
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        if (branch_taken) begin
          // An older branch proved the syscall speculative: resume at target.
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (tgt_misaligned) begin
            state_d = ST_ERR;
          end else begin
            pc_d    = redirect_tgt;
            state_d = ST_RUN;
          end
        end else if (!stall) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
      end

      ST_ERR: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end

      default: begin
        // Unreachable encoding: fail safe into the sticky error state.
        state_d = ST_ERR;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Moore outputs straight from registers.
  assign pc_out     = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == ST_HALT);
  assign fetch_err  = (state_q == ST_ERR);

  // Structural invariants: fetch address stays word-aligned, and the two
  // status flags are never raised together.
  a_pc_aligned : assert property (@(posedge clk) disable iff (rst)
    pc_q[1:0] == 2'b00);
  a_flags_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(halted && fetch_err));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with constant
// expectations followed by randomized control traffic compared cycle by cycle
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  pc_out;
  logic [31:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        jump;
  logic [7:0]  jump_target;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Instruction memory: 64 words, combinational read of pc_out.
  logic [31:0] mem [64];
  assign instr_in = mem[pc_out[7:2]];

  // Behavioural model of the visible fetch state.
  int          m_pc;
  int          m_pc4;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_halt;
  bit          m_err;

  // Packed observation: {pc, instr, pc4, valid, halted, err}.
  logic [50:0] got;
  logic [50:0] exp;

  fetch_stage #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_out        (pc_out),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_err     (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    m_pc = 0; m_pc4 = 0; m_instr = '0; m_valid = 0; m_halt = 0; m_err = 0;
  endfunction

  function automatic void model_bubble();
    m_instr = '0; m_pc4 = 0; m_valid = 0;
  endfunction

  // One clock edge of the fetch rules, using the inputs as currently driven.
  function automatic void model_step();
    int tgt;
    if (m_err) begin
      model_bubble();
    end else if (branch_taken || (jump && !m_halt)) begin
      tgt = branch_taken ? int'(branch_target) : int'(jump_target);
      model_bubble();
      if (tgt % 4 != 0) begin
        m_err  = 1;
        m_halt = 0;
      end else begin
        m_pc   = tgt;
        m_halt = 0;
      end
    end else if (stall) begin
      // everything holds
    end else if (m_halt) begin
      model_bubble();
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = (m_pc + 4) % 256;
      m_valid = 1;
      if (m_instr == 32'h0000_000C) m_halt = 1;
      else m_pc = (m_pc + 4) % 256;
    end
  endfunction

  function automatic logic [50:0] model_vec();
    return {8'(m_pc), m_instr, 8'(m_pc4), m_valid, m_halt, m_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
  endtask

  // Asynchronous reset pulse starting away from any clock edge.
  task automatic do_reset();
    clear_ctrl();
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    fill_mem();
    clear_ctrl();
    rst = 1;
    model_reset();
    #1;
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_state got %h want %h", got, exp); end
    @(negedge clk);
    rst = 0;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h04, 32'h11, 8'h04, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL seq_fetch0 got %h want %h", got, exp); end
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h08, 32'h22, 8'h08, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL seq_fetch1 got %h want %h", got, exp); end
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h0C, 32'h33, 8'h0C, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL seq_fetch2 got %h want %h", got, exp); end
  endtask

  task automatic test_stall_branch();
    do_reset();
    tick();
    tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
      exp = {8'h08, 32'h22, 8'h08, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_hold%0d got %h want %h", i, got, exp); end
    end
    branch_taken  = 1;
    branch_target = 8'h40;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h40, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL branch_over_stall got %h want %h", got, exp); end
    clear_ctrl();
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h44, 32'hA500_0010, 8'h44, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL branch_target_fetch got %h want %h", got, exp); end
  endtask

  task automatic test_wrap();
    jump        = 1;
    jump_target = 8'hFC;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'hFC, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL jump_redirect got %h want %h", got, exp); end
    clear_ctrl();
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h00, 32'hA500_003F, 8'h00, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_fc got %h want %h", got, exp); end
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h04, 32'h11, 8'h04, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_resume got %h want %h", got, exp); end
  endtask

  task automatic test_syscall();
    mem[4] = 32'h0000_000C;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h10, 32'h0000_000C, 8'h14, 1'b1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL syscall_latch got %h want %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      // A jump while halted must be ignored.
      jump        = (i == 1);
      jump_target = 8'h80;
      stall       = (i == 2);
      tick();
      got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
      exp = {8'h10, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL halt_hold%0d got %h want %h", i, got, exp); end
    end
    clear_ctrl();
    branch_taken  = 1;
    branch_target = 8'h20;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h20, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_cancel got %h want %h", got, exp); end
    clear_ctrl();
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h24, 32'hA500_0008, 8'h24, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_resume got %h want %h", got, exp); end
    mem[4] = 32'hA500_0004;
  endtask

  task automatic test_misaligned();
    branch_taken  = 1;
    branch_target = 8'h06;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h24, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL misaligned_enter got %h want %h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      clear_ctrl();
      jump          = (i == 0);
      jump_target   = 8'h40;
      branch_taken  = (i == 1);
      branch_target = 8'h40;
      stall         = (i == 3);
      tick();
      got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL err_sticky%0d got %h want %h", i, got, exp); end
    end
    clear_ctrl();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    stall = 1;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h24, 32'hA500_0008, 8'h24, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL pre_reset_pc got %h want %h", got, exp); end
    #2;
    rst = 1;
    model_reset();
    #1;
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset got %h want %h", got, exp); end
    @(negedge clk);
    rst   = 0;
    stall = 0;
    tick();
    got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
    exp = {8'h04, 32'h11, 8'h04, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL post_reset_fetch got %h want %h", got, exp); end
  endtask

  function automatic logic [7:0] rand_target();
    logic [7:0] t;
    t = {6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 19) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0000_000C : $urandom;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (m_err && $urandom_range(0, 5) == 0) begin
        #2;
        do_reset();
        #1;
        got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
        exp = model_vec();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_reset cyc%0d got %h want %h", cyc, got, exp); end
      end
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_target = rand_target();
      jump_target   = rand_target();
      tick();
      got = {pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_err};
      exp = model_vec();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand cyc%0d got %h want %h", cyc, got, exp); end
    end
    clear_ctrl();
  endtask

  initial begin
    rst = 1;
    clear_ctrl();
    test_reset();
    test_stall_branch();
    test_wrap();
    test_syscall();
    test_misaligned();
    fill_mem();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
